// File: rtl/final_layer_loader_if.sv
// Byte-stream handshake between the chip-level front end (master) and the
// final-layer operand loader (slave).
interface final_layer_loader_if #(
    parameter int BUS_W = 8
) ();
    logic [BUS_W-1:0] byte_in;
    logic             byte_valid;
    logic             byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/final_layer_loader.sv
// Byte-serial loader for the final BNN layer: packs class weight vectors and the
// flattened activation vector LSB-first from a valid/ready byte stream.
module final_layer_loader #(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_CLASSES = 10,
    parameter int BUS_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  data_only,
    final_layer_loader_if.slave   bus,
    output logic [NUM_INPUTS-1:0] data_out,
    output logic [NUM_INPUTS-1:0] weights_out [NUM_CLASSES-1:0],
    output logic                  out_valid,
    output logic                  done
);

    localparam int NBYTES = (NUM_INPUTS + BUS_W - 1) / BUS_W;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int VIDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BIDX_W-1:0] byte_idx;
    logic [VIDX_W-1:0] vec_idx;
    logic              accept;
    logic              last_byte;
    logic              last_vec;
    logic              start_ok;
    logic              w_accept;
    logic              d_accept;
    logic [NUM_INPUTS-1:0] data_next;

    // Ready and out_valid decode straight from the state flops, never from byte_valid.
    assign bus.byte_ready = (state == LOAD_W) || (state == LOAD_D);
    assign out_valid      = (state == DONE);

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign last_byte = (byte_idx == BIDX_W'(NBYTES - 1));
    assign last_vec  = (vec_idx == VIDX_W'(NUM_CLASSES - 1));
    assign start_ok  = load_start && ((state == IDLE) || (state == DONE));
    assign w_accept  = accept && (state == LOAD_W);
    assign d_accept  = accept && (state == LOAD_D);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    state_next = data_only ? LOAD_D : LOAD_W;
                end
            end
            LOAD_W: begin
                if (accept && last_byte && last_vec) begin
                    state_next = LOAD_D;
                end
            end
            LOAD_D: begin
                if (accept && last_byte) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // byte_idx wraps per vector; vec_idx only steps while weights are streaming.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            vec_idx  <= '0;
            done     <= 1'b0;
        end else begin
            done <= d_accept && last_byte;
            if (start_ok) begin
                byte_idx <= '0;
                vec_idx  <= '0;
            end else if (accept) begin
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                if (state == LOAD_W && last_byte) begin
                    vec_idx <= last_vec ? '0 : vec_idx + 1'b1;
                end
            end
        end
    end

    // Each vector bit maps to a fixed (byte, bit) slot; bits past NUM_INPUTS never exist.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_dbit
        assign data_next[i] = (d_accept && byte_idx == BIDX_W'(i / BUS_W))
                            ? bus.byte_in[i % BUS_W] : data_out[i];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else begin
            data_out <= data_next;
        end
    end

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        logic                  hit;
        logic [NUM_INPUTS-1:0] wnext;

        assign hit = w_accept && (vec_idx == VIDX_W'(c));

        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_wbit
            assign wnext[i] = (hit && byte_idx == BIDX_W'(i / BUS_W))
                            ? bus.byte_in[i % BUS_W] : weights_out[c][i];
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                weights_out[c] <= '0;
            end else begin
                weights_out[c] <= wnext;
            end
        end
    end

endmodule

// File: doc/final_layer_loader.md
# final_layer_loader

Byte-serial loader that fills the operand registers of the final BNN classification layer. It accepts the 10 class weight vectors and the flattened 196-bit activation vector over an 8-bit valid/ready byte stream, packs them LSB-first, and holds them on parallel outputs for the flatten/final layer's `data_in` and `weights_in` inputs. It sits between the chip-level byte interface (pins/SPI front end) and the final layer. It supports a full reload (weights plus data) or a data-only reload that keeps resident weights.

## Interface
- `NUM_INPUTS`, default 196: bits per activation vector and per weight vector.
- `NUM_CLASSES`, default 10: number of weight vectors.
- `BUS_W`, default 8: byte-stream width.
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state and outputs.
- `load_start`, input, 1: one-cycle request to begin a load.
- `data_only`, input, 1: sampled with `load_start`. 1 = skip weights and load only the data vector.
- `byte_in`, input, `BUS_W`: stream byte.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `data_out`, output, `NUM_INPUTS`: packed activation vector; drives the final layer's `data_in`.
- `weights_out [NUM_CLASSES-1:0]`, output, `NUM_INPUTS` each: packed weight vectors; drive the final layer's `weights_in`.
- `out_valid`, output, 1: `data_out` and `weights_out` are complete and stable.
- `done`, output, 1: one-cycle pulse when a load completes.

## Operation
- Bytes per vector: `NBYTES = ceil(NUM_INPUTS/BUS_W)`, which is 25 at defaults.
- Packing: byte k, bit b maps to vector bit `BUS_W*k+b`. In the last byte of a vector, bits at index `>= NUM_INPUTS` are discarded (bits 7:4 at defaults).
- Stream order for a full load: weights class 0 … class `NUM_CLASSES-1`, then data. A full load is 275 bytes at defaults. A data-only load is the data vector only, 25 bytes.
- A byte is accepted on a cycle with `byte_valid && byte_ready`. Accepted bits are written directly into the target register.
- Counters:
  - `byte_idx` runs 0..`NBYTES-1` and wraps to 0 at the end of each vector.
  - `vec_idx` runs 0..`NUM_CLASSES-1` and advances on `byte_idx` wrap in LOAD_W.
- FSM states:
  - IDLE: `byte_ready`=0. `load_start` moves to LOAD_D if `data_only`=1, otherwise LOAD_W.
  - LOAD_W: `byte_ready`=1. After the last byte of class `NUM_CLASSES-1`, go to LOAD_D with counters at 0.
  - LOAD_D: `byte_ready`=1. After the last data byte is accepted, go to DONE and pulse `done` on the next cycle.
  - DONE: `byte_ready`=0, `out_valid`=1. `load_start` is accepted as in IDLE.
- On an accepted `load_start`: `out_valid` clears the next cycle and the counters reset to 0.
- Data-only load: `weights_out` is untouched. Full load: both `weights_out` and `data_out` are overwritten.
- `load_start` during LOAD_W or LOAD_D is ignored; a load is never restarted mid-stream.
- `byte_valid` in IDLE or DONE is ignored and no byte is consumed.
- A data-only load issued after reset, before any full load, is legal. The weights stay all-zero.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, and all `data_out`/`weights_out` bits 0.
- `byte_ready` is a registered function of state only. It never depends combinationally on `byte_valid`.
- `byte_ready` rises 1 cycle after `load_start` is sampled.
- Full-rate throughput is 1 byte per cycle. Gaps in `byte_valid` stall the load with no data loss.
- On the last accepted byte: state DONE, `byte_ready` low, and `out_valid` high, all on the next cycle. `done` is high for exactly that first DONE cycle.
- Minimum load latency, measured from `load_start` to `out_valid`:
  - full load: 1 + 275 + 1 cycles at defaults;
  - data-only load: 1 + 25 + 1 cycles.
- `data_out` and `weights_out` change only on accepted bytes or on reset.
- Reset asserted mid-load: outputs and registers clear immediately (asynchronously). After deassertion the block is in IDLE, and a new `load_start` is required.

## Test plan
- Reset then idle: hold `reset`=0 and check all outputs are 0. Release and drive `byte_valid`=1 with no `load_start`. Expect `byte_ready`=0 and no register change.
- Full load, byte k value = k mod 256, continuous valid: 275 bytes accepted. Expect:
  - `done` pulses once and `out_valid`=1 on the following cycles;
  - `weights_out[0][7:0]`=8'h00 and `weights_out[0][15:8]`=8'h01;
  - `weights_out[0][195:192]`=4'h8, from byte 24=8'h18 with the high nibble dropped;
  - `data_out[195:192]`=byte 274 & 4'hF = 4'h2.
- Stalled stream: repeat the full load with `byte_valid` toggling every other cycle. Expect identical final outputs and `done` after 550 + 2 cycles.
- Data-only reload after a full load: 25 bytes of 8'hFF. Expect `data_out`=all ones and `weights_out` unchanged. `out_valid` is 0 during the load and 1 after `done`.
- `load_start` mid-load: pulse it at byte 100 of a full load. Expect it to be ignored; the byte count continues to 275 and only one `done` pulse occurs.
- Reset mid-load: assert `reset` at byte 50. Expect the outputs to clear asynchronously. After release, a fresh full load completes correctly.
